// File: rtl/mem_port_arbiter_if.sv
// Bundle of the two pipeline memory slots plus the single cache port and perf counters.
// master = arbiter side, slave = pipeline/cache side.
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          MemReqA;
  logic          MemReqB;
  logic          MemWrA;
  logic          MemWrB;
  logic [AW-1:0] AddrA;
  logic [AW-1:0] AddrB;
  logic [DW-1:0] WDataA;
  logic [DW-1:0] WDataB;
  logic          Ren;
  logic          Wen;
  logic [AW-1:0] Addr;
  logic [DW-1:0] WriteData;
  logic          CacheReady;
  logic [DW-1:0] ReadData;
  logic [DW-1:0] RDataA;
  logic [DW-1:0] RDataB;
  logic          StallM;
  logic [31:0]   StallCnt;
  logic [31:0]   ConflictCnt;

  modport master (
    input  MemReqA, MemReqB, MemWrA, MemWrB, AddrA, AddrB, WDataA, WDataB,
    input  CacheReady, ReadData,
    output Ren, Wen, Addr, WriteData, RDataA, RDataB, StallM, StallCnt, ConflictCnt
  );

  modport slave (
    output MemReqA, MemReqB, MemWrA, MemWrB, AddrA, AddrB, WDataA, WDataB,
    output CacheReady, ReadData,
    input  Ren, Wen, Addr, WriteData, RDataA, RDataB, StallM, StallCnt, ConflictCnt
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Serialises dual-issue memory slots A then B onto one cache port, stalling the M stage.
// Optional performance counters are built when MEM_ARB_PERF_EN is defined.
module mem_port_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic                clk,
  input  logic                resetn,
  mem_port_arbiter_if.master  bus
);

  typedef enum logic [1:0] {IDLE, ACC_A, ACC_B, DONE} state_t;

  state_t        state_reg;
  state_t        state_next;

  logic          req_b_reg;
  logic          wr_a_reg;
  logic          wr_b_reg;
  logic [AW-1:0] addr_a_reg;
  logic [AW-1:0] addr_b_reg;
  logic [DW-1:0] wdata_a_reg;
  logic [DW-1:0] wdata_b_reg;
  logic [DW-1:0] rdata_a_reg;
  logic [DW-1:0] rdata_b_reg;

  logic          any_req;
  logic          ren;
  logic          wen;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          stall;

  assign any_req = bus.MemReqA | bus.MemReqB;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (bus.MemReqA) begin
          state_next = ACC_A;
        end else if (bus.MemReqB) begin
          state_next = ACC_B;
        end
      end
      ACC_A: begin
        if (bus.CacheReady) begin
          state_next = req_b_reg ? ACC_B : DONE;
        end
      end
      ACC_B: begin
        if (bus.CacheReady) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Cache strobes come only from the state and latched copies, so they hold while the cache waits.
  always_comb begin
    ren   = 1'b0;
    wen   = 1'b0;
    addr  = '0;
    wdata = '0;
    stall = 1'b0;
    case (state_reg)
      IDLE: stall = any_req;
      ACC_A: begin
        stall = 1'b1;
        ren   = ~wr_a_reg;
        wen   = wr_a_reg;
        addr  = addr_a_reg;
        wdata = wdata_a_reg;
      end
      ACC_B: begin
        stall = 1'b1;
        ren   = ~wr_b_reg;
        wen   = wr_b_reg;
        addr  = addr_b_reg;
        wdata = wdata_b_reg;
      end
      default: stall = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      req_b_reg   <= 1'b0;
      wr_a_reg    <= 1'b0;
      wr_b_reg    <= 1'b0;
      addr_a_reg  <= '0;
      addr_b_reg  <= '0;
      wdata_a_reg <= '0;
      wdata_b_reg <= '0;
    end else if (state_reg == IDLE && any_req) begin
      req_b_reg   <= bus.MemReqB;
      wr_a_reg    <= bus.MemWrA & bus.MemReqA;
      wr_b_reg    <= bus.MemWrB & bus.MemReqB;
      addr_a_reg  <= bus.AddrA;
      addr_b_reg  <= bus.AddrB;
      wdata_a_reg <= bus.WDataA;
      wdata_b_reg <= bus.WDataB;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rdata_a_reg <= '0;
      rdata_b_reg <= '0;
    end else begin
      if (state_reg == ACC_A && bus.CacheReady && !wr_a_reg) begin
        rdata_a_reg <= bus.ReadData;
      end
      if (state_reg == ACC_B && bus.CacheReady && !wr_b_reg) begin
        rdata_b_reg <= bus.ReadData;
      end
    end
  end

  assign bus.Ren       = ren;
  assign bus.Wen       = wen;
  assign bus.Addr      = addr;
  assign bus.WriteData = wdata;
  assign bus.StallM    = stall;
  assign bus.RDataA    = rdata_a_reg;
  assign bus.RDataB    = rdata_b_reg;

`ifdef MEM_ARB_PERF_EN
  logic [31:0] stall_cnt_reg;
  logic [31:0] conflict_cnt_reg;

  // Both counters wrap naturally at 2^32.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stall_cnt_reg    <= '0;
      conflict_cnt_reg <= '0;
    end else begin
      if (stall) begin
        stall_cnt_reg <= stall_cnt_reg + 32'd1;
      end
      if (state_reg == IDLE && bus.MemReqA && bus.MemReqB) begin
        conflict_cnt_reg <= conflict_cnt_reg + 32'd1;
      end
    end
  end

  assign bus.StallCnt    = stall_cnt_reg;
  assign bus.ConflictCnt = conflict_cnt_reg;
`else
  assign bus.StallCnt    = 32'd0;
  assign bus.ConflictCnt = 32'd0;
`endif

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter: AW, 32, address width.
REQ-002 Parameter: DW, 32, data width.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 resetn  in  1  asynchronous, active-low reset.
REQ-005 MemReqA / MemReqB  in  1  slot A/B needs memory this bundle (load or store).
REQ-006 MemWrA / MemWrB  in  1  slot A/B access is a store (valid only with MemReq).
REQ-007 AddrA / AddrB  in  AW  slot A/B address.
REQ-008 WDataA / WDataB  in  DW  slot A/B store data.
REQ-009 Ren / Wen  out  1  cache read / write strobe.
REQ-010 Addr / WriteData  out  AW/DW  cache address / store data.
REQ-011 CacheReady  in  1  cache completes the current access this cycle.
REQ-012 ReadData  in  DW  cache load data, valid with CacheReady.
REQ-013 RDataA / RDataB  out  DW  registered load result per slot.
REQ-014 StallM  out  1  hold the M stage and all earlier stages.
REQ-015 StallCnt / ConflictCnt  out  32  performance counters (see Configuration).

Function
REQ-016 The arbiter SHALL serialise the two slots onto the single cache port in program order: A before B.
REQ-017 States SHALL be IDLE, ACC_A, ACC_B and DONE.
REQ-018 IDLE, neither MemReq set: StallM=0 and the state SHALL stay IDLE.
REQ-019 IDLE, any MemReq set: StallM=0 is not allowed; StallM SHALL be 1 combinationally in that cycle.
REQ-020 IDLE, any MemReq set: the arbiter SHALL latch both slots' Req, Wr, Addr and WData.
REQ-021 IDLE, any MemReq set: next state SHALL be ACC_A if MemReqA, else ACC_B.
REQ-022 ACC_x: the block SHALL drive Addr/WriteData from slot x's latched values.
REQ-023 ACC_x: Wen SHALL equal latched Wr_x, Ren SHALL equal ~latched Wr_x, and StallM=1.
REQ-024 Ren and Wen SHALL never both be 1 and SHALL be 0 outside ACC states.
REQ-025 ACC_x with CacheReady=0: the state and all cache outputs SHALL hold unchanged.
REQ-026 ACC_x with CacheReady=1 and a load: RData_x SHALL capture ReadData on that edge.
REQ-027 ACC_x with CacheReady=1: ACC_A SHALL go to ACC_B if latched ReqB, otherwise to DONE; ACC_B SHALL go to DONE.
REQ-028 DONE: StallM=0 for exactly one cycle so the pipeline advances; next state SHALL be IDLE.
REQ-029 DONE: MemReq inputs SHALL be ignored.
REQ-030 RDataA/RDataB SHALL hold their values until the next load to the same slot completes.
REQ-031 Inputs changing while in ACC/DONE SHALL have no effect; only latched copies are used.
REQ-032 Latency with CacheReady tied high: one access 3 cycles (IDLE, ACC, DONE); two accesses 4 cycles.
REQ-033 A store in A followed by a load in B to the same address SHALL return the stored data, guaranteed by ordering.

Reset
REQ-034 resetn low SHALL force state IDLE immediately, asynchronously.
REQ-035 resetn low SHALL force StallM=0 (no MemReq), Ren=Wen=0 and all latched and captured data, including RDataA/RDataB, to 0.
REQ-036 resetn low SHALL clear the counters to 0.
REQ-037 Reset asserted during ACC_x SHALL drop Ren/Wen in the same cycle; the in-flight access is abandoned.
REQ-038 After reset deassertion, the first MemReq SHALL be sampled on the first rising edge.

Configuration
REQ-039 Macro MEM_ARB_PERF_EN defined: StallCnt SHALL increment on every cycle with StallM=1.
REQ-040 Macro MEM_ARB_PERF_EN defined: ConflictCnt SHALL increment once per bundle with both MemReqA and MemReqB set in IDLE.
REQ-041 Macro MEM_ARB_PERF_EN defined: both counters SHALL wrap modulo 2^32.
REQ-042 Macro MEM_ARB_PERF_EN undefined: both ports SHALL remain and be tied to constant 0, with no counter flops.

Verification
REQ-043 Load A only, AddrA=0x100, CacheReady high, ReadData=0xDEADBEEF -> Ren=1 and Addr=0x100 for 1 cycle; RDataA=0xDEADBEEF; StallM high 2 cycles, then low 1 cycle.
REQ-044 Store A to 0x200 with 0x11 plus load B from 0x204, CacheReady high -> Wen cycle at 0x200 then Ren cycle at 0x204; ConflictCnt=1 with macro, StallCnt=3.
REQ-045 Load B only, CacheReady low 3 cycles then high -> Addr held stable 4 cycles; StallM=1 for 5 cycles; RDataB captured only on the ready edge.
REQ-046 resetn pulsed low mid-ACC_B -> Ren/Wen=0 immediately; state IDLE; RDataA/RDataB=0; counters=0.
REQ-047 No MemReq for 10 cycles -> StallM=0, Ren=Wen=0 throughout; counters unchanged.
REQ-048 Build without MEM_ARB_PERF_EN, rerun REQ-044 -> identical port traffic; StallCnt=ConflictCnt=0.
